// File: rtl/pack_arbiter_if.sv
// rtl/pack_arbiter_if.sv - requester and downstream handshake bundle for pack_arbiter
interface pack_arbiter_if #(
    parameter int W = 2
);
    logic           req0;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    logic           gnt0;
    logic           req1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic           gnt1;
    logic [2*W-1:0] out_data;
    logic           out_src;
    logic           out_valid;
    logic           out_ready;

    // master is the arbiter side, slave is the requester/downstream environment
    modport master (
        input  req0, a0, b0, req1, a1, b1, out_ready,
        output gnt0, gnt1, out_data, out_src, out_valid
    );

    modport slave (
        output req0, a0, b0, req1, a1, b1, out_ready,
        input  gnt0, gnt1, out_data, out_src, out_valid
    );
endinterface

// File: rtl/pack_arbiter.sv
// rtl/pack_arbiter.sv - two-requester pack-and-register arbiter; PACK_ARB_FIXED_PRIO_EN selects fixed priority
module pack_arbiter #(
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    pack_arbiter_if.master   bus,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    logic   last;
    logic   can_load;
    logic   tie0_wins;
    logic   gnt0_c;
    logic   gnt1_c;

    always_comb begin
        can_load = (state == EMPTY) | bus.out_ready;
`ifdef PACK_ARB_FIXED_PRIO_EN
        tie0_wins = 1'b1 | last;
`else
        // last=1 means requester 1 was served most recently, so 0 wins the tie
        tie0_wins = last;
`endif
        gnt0_c = !rst & can_load & bus.req0 & (!bus.req1 | tie0_wins);
        gnt1_c = !rst & can_load & bus.req1 & (!bus.req0 | !tie0_wins);
    end

    assign bus.gnt0 = gnt0_c;
    assign bus.gnt1 = gnt1_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= 1'b0;
            last          <= 1'b1;
            cnt0          <= '0;
            cnt1          <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (gnt0_c | gnt1_c) begin
                        state         <= FULL;
                        bus.out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    // a grant in FULL implies out_ready, so drain and reload coincide
                    if (!(gnt0_c | gnt1_c) && bus.out_ready) begin
                        state         <= EMPTY;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    bus.out_valid <= 1'b0;
                end
            endcase

            if (gnt0_c | gnt1_c) begin
                bus.out_data <= gnt1_c ? {bus.a1, bus.b1} : {bus.a0, bus.b0};
                bus.out_src  <= gnt1_c;
                last         <= gnt1_c;
            end

            if (gnt0_c && cnt0 != CNT_MAX) cnt0 <= cnt0 + CNT_W'(1);
            if (gnt1_c && cnt1 != CNT_MAX) cnt1 <= cnt1 + CNT_W'(1);
        end
    end
endmodule
